cim_serial_add_seq: RTL and testbench

- Sequencer that drives the in-memory compute datapath through a multi-bit, bit-serial vector addition.
- Operands are stored transposed: bit i of each of 32 lanes sits in SRAM row base+i.
- The block issues row reads, selects the serial-adder result, controls the carry register and writes each sum bit row back.
- It sits between the command/Avalon front end and the SRAM/datapath control inputs, alongside rw_control.

---
 rtl/cim_serial_add_seq.sv | 150 +++++++++++++++
 tb/tb_cim_serial_add_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_serial_add_seq.sv
// Bit-serial vector add sequencer for the in-memory compute array (32 lanes, transposed operands).
// Optional macro CIM_SEQ_PERF_CNT_EN adds a saturating busy-cycle counter output cyc_count_out.
module cim_serial_add_seq #(
    parameter int NBITS_W = 6,
    parameter int ADDR_W  = 8
) (
    input  logic               sys_clk_in,
    input  logic               sys_reset_in,
    input  logic               start_in,
    input  logic [ADDR_W-1:0]  base_a_in,
    input  logic [ADDR_W-1:0]  base_b_in,
    input  logic [ADDR_W-1:0]  base_dst_in,
    input  logic [NBITS_W-1:0] nbits_in,
    input  logic               carry_init_in,
    input  logic [31:0]        compute_data_in,
    output logic [ADDR_W-1:0]  sram_addr_a_out,
    output logic [ADDR_W-1:0]  sram_addr_b_out,
    output logic [31:0]        sram_data_a_out,
    output logic               sram_wren_a_out,
    output logic [63:0]        compute_sel_out,
    output logic [3:0]         read_sel_out,
    output logic               load_carry_out,
    output logic               update_carry_out,
    output logic [31:0]        carry_out,
    output logic               busy_out,
    output logic               done_out,
    output logic               err_out
`ifdef CIM_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]        cyc_count_out
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base_a_q;
    logic [ADDR_W-1:0]  base_b_q;
    logic [ADDR_W-1:0]  base_dst_q;
    logic [NBITS_W-1:0] nbits_q;
    logic [NBITS_W-1:0] bit_idx;
    logic [NBITS_W-1:0] next_idx;
    logic [ADDR_W-1:0]  cur_off;
    logic [ADDR_W-1:0]  nxt_off;

    always_comb begin
        next_idx = bit_idx + 1'b1;
        cur_off  = ADDR_W'(bit_idx);
        nxt_off  = ADDR_W'(next_idx);
    end

    assign compute_sel_out = '1;
    // The adder sum is only valid while the bitlines hold the READ rows, so it passes straight through.
    assign sram_data_a_out = (state == WRITE) ? compute_data_in : '0;

    always_ff @(posedge sys_clk_in) begin
        if (sys_reset_in) begin
            state            <= IDLE;
            base_a_q         <= '0;
            base_b_q         <= '0;
            base_dst_q       <= '0;
            nbits_q          <= '0;
            bit_idx          <= '0;
            sram_addr_a_out  <= '0;
            sram_addr_b_out  <= '0;
            sram_wren_a_out  <= 1'b0;
            read_sel_out     <= '0;
            load_carry_out   <= 1'b0;
            update_carry_out <= 1'b0;
            carry_out        <= '0;
            busy_out         <= 1'b0;
            done_out         <= 1'b0;
            err_out          <= 1'b0;
        end else begin
            done_out <= 1'b0;
            err_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        if (nbits_in == '0) begin
                            err_out <= 1'b1;
                        end else begin
                            base_a_q       <= base_a_in;
                            base_b_q       <= base_b_in;
                            base_dst_q     <= base_dst_in;
                            nbits_q        <= nbits_in;
                            bit_idx        <= '0;
                            load_carry_out <= 1'b1;
                            carry_out      <= {32{carry_init_in}};
                            busy_out       <= 1'b1;
                            state          <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    load_carry_out  <= 1'b0;
                    sram_addr_a_out <= base_a_q;
                    sram_addr_b_out <= base_b_q;
                    read_sel_out    <= 4'd0;
                    state           <= READ;
                end
                READ: begin
                    sram_addr_a_out  <= base_dst_q + cur_off;
                    read_sel_out     <= 4'd8;
                    sram_wren_a_out  <= 1'b1;
                    update_carry_out <= 1'b1;
                    state            <= WRITE;
                end
                WRITE: begin
                    sram_wren_a_out  <= 1'b0;
                    update_carry_out <= 1'b0;
                    read_sel_out     <= 4'd0;
                    if (bit_idx == nbits_q - 1'b1) begin
                        sram_addr_a_out <= '0;
                        sram_addr_b_out <= '0;
                        busy_out        <= 1'b0;
                        done_out        <= 1'b1;
                        state           <= DONE;
                    end else begin
                        bit_idx         <= next_idx;
                        sram_addr_a_out <= base_a_q + nxt_off;
                        sram_addr_b_out <= base_b_q + nxt_off;
                        state           <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CIM_SEQ_PERF_CNT_EN
    always_ff @(posedge sys_clk_in) begin
        if (sys_reset_in) begin
            cyc_count_out <= '0;
        end else if (state == IDLE && start_in && nbits_in != '0) begin
            cyc_count_out <= '0;
        end else if (busy_out && cyc_count_out != 16'hFFFF) begin
            cyc_count_out <= cyc_count_out + 16'd1;
        end
    end
`else
    // Default build carries no cycle counter.
`endif

endmodule

// File: tb/tb_cim_serial_add_seq.sv
// Self-checking bench for cim_serial_add_seq: SRAM + serial-adder model, write/read scoreboard.
module tb_cim_serial_add_seq;

    logic        sys_clk;
    logic        sys_reset;
    logic        start_in;
    logic [7:0]  base_a;
    logic [7:0]  base_b;
    logic [7:0]  base_dst;
    logic [5:0]  nbits;
    logic        carry_init;
    logic [31:0] compute_data;
    logic [7:0]  sram_addr_a;
    logic [7:0]  sram_addr_b;
    logic [31:0] sram_data_a;
    logic        sram_wren_a;
    logic [63:0] compute_sel;
    logic [3:0]  read_sel;
    logic        load_carry;
    logic        update_carry;
    logic [31:0] carry_val;
    logic        busy;
    logic        done;
    logic        err;
`ifdef CIM_SEQ_PERF_CNT_EN
    logic [15:0] cyc_count;
`endif

    cim_serial_add_seq dut (
        .sys_clk_in      (sys_clk),
        .sys_reset_in    (sys_reset),
        .start_in        (start_in),
        .base_a_in       (base_a),
        .base_b_in       (base_b),
        .base_dst_in     (base_dst),
        .nbits_in        (nbits),
        .carry_init_in   (carry_init),
        .compute_data_in (compute_data),
        .sram_addr_a_out (sram_addr_a),
        .sram_addr_b_out (sram_addr_b),
        .sram_data_a_out (sram_data_a),
        .sram_wren_a_out (sram_wren_a),
        .compute_sel_out (compute_sel),
        .read_sel_out    (read_sel),
        .load_carry_out  (load_carry),
        .update_carry_out(update_carry),
        .carry_out       (carry_val),
        .busy_out        (busy),
        .done_out        (done),
        .err_out         (err)
`ifdef CIM_SEQ_PERF_CNT_EN
        ,
        .cyc_count_out   (cyc_count)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Registered-q SRAM and a 32-lane serial full adder with its carry register.
    logic [31:0] mem [0:255];
    logic [31:0] q_a;
    logic [31:0] q_b;
    logic [31:0] carry_reg;
    logic [31:0] sum_w;
    logic [31:0] carry_next;

    assign sum_w        = q_a ^ q_b ^ carry_reg;
    assign carry_next   = (q_a & q_b) | (q_a & carry_reg) | (q_b & carry_reg);
    assign compute_data = (read_sel == 4'd8) ? sum_w : q_a;

    always @(posedge sys_clk) begin
        q_a <= mem[sram_addr_a];
        q_b <= mem[sram_addr_b];
        if (sram_wren_a) mem[sram_addr_a] <= sram_data_a;
        if (load_carry) carry_reg <= carry_val;
        else if (update_carry) carry_reg <= carry_next;
    end

    typedef struct packed { logic [7:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [7:0] a; logic [7:0] b; } rd_t;
    wr_t exp_wr[$];
    rd_t exp_rd[$];

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: pop expected writes/reads as the DUT performs them.
    always @(negedge sys_clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (load_carry && update_carry) checkOutput("carry_ctrl_excl", 1, 0);
        if (sram_wren_a) begin
            if (exp_wr.size() == 0) begin
                checkOutput("wr_unexpected", {56'd0, sram_addr_a}, 64'hFFFF);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                checkOutput("wr_addr", sram_addr_a, w.addr);
                checkOutput("wr_data", sram_data_a, w.data);
                checkOutput("wr_read_sel", read_sel, 4'd8);
            end
        end else if (busy && !load_carry) begin
            if (exp_rd.size() == 0) begin
                checkOutput("rd_unexpected", {48'd0, sram_addr_a, sram_addr_b}, 64'hFFFFF);
            end else begin
                rd_t r;
                r = exp_rd.pop_front();
                checkOutput("rd_addr_a", sram_addr_a, r.a);
                checkOutput("rd_addr_b", sram_addr_b, r.b);
                checkOutput("rd_read_sel", read_sel, 4'd0);
            end
        end
    end

    task automatic pushExpected(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bd,
                                input int n, input logic cin, input int limit);
        logic [63:0] av, bv, sv;
        logic [31:0] rows [0:63];
        for (int i = 0; i < 64; i++) rows[i] = '0;
        for (int lane = 0; lane < 32; lane++) begin
            av = '0;
            bv = '0;
            for (int i = 0; i < n; i++) begin
                av[i] = mem[8'(ba + 8'(i))][lane];
                bv[i] = mem[8'(bb + 8'(i))][lane];
            end
            sv = av + bv + {63'd0, cin};
            for (int i = 0; i < n; i++) rows[i][lane] = sv[i];
        end
        for (int i = 0; i < limit; i++) begin
            exp_wr.push_back('{addr: 8'(bd + 8'(i)), data: rows[i]});
            exp_rd.push_back('{a: 8'(ba + 8'(i)), b: 8'(bb + 8'(i))});
        end
    endtask

    task automatic checkIdleOutputs(input string pfx);
        checkOutput({pfx, "_busy"}, busy, 0);
        checkOutput({pfx, "_done"}, done, 0);
        checkOutput({pfx, "_err"}, err, 0);
        checkOutput({pfx, "_wren"}, sram_wren_a, 0);
        checkOutput({pfx, "_addr"}, {sram_addr_a, sram_addr_b}, 0);
        checkOutput({pfx, "_data"}, sram_data_a, 0);
        checkOutput({pfx, "_read_sel"}, read_sel, 0);
        checkOutput({pfx, "_carry_ctl"}, {load_carry, update_carry}, 0);
        checkOutput({pfx, "_carry_out"}, carry_val, 0);
        checkOutput({pfx, "_compute_sel"}, compute_sel, 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    // Runs one command; intrude = cycle to pulse a stray start, reset_cyc = cycle to assert reset.
    task automatic applyStimulus(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bd,
                                 input int n, input logic cin, input int intrude, input int reset_cyc);
        int got;
        int limit;
        limit = (reset_cyc > 0) ? (reset_cyc - 1) / 2 : n;
        pushExpected(ba, bb, bd, n, cin, limit);
        @(negedge sys_clk);
        busy_cnt = 0;
        done_cnt = 0;
        err_cnt  = 0;
        base_a = ba; base_b = bb; base_dst = bd; nbits = 6'(n); carry_init = cin;
        start_in = 1'b1;
        got = 0;
        for (int k = 1; k <= 2 * n + 10; k++) begin
            @(negedge sys_clk);
            start_in = (k == intrude);
            if (k == 1) begin
                checkOutput("load_carry", load_carry, 1);
                checkOutput("carry_preload", carry_val, {32{cin}});
                checkOutput("busy_start", busy, 1);
            end
            if (reset_cyc > 0 && k == reset_cyc) begin
                sys_reset = 1'b1;
                @(negedge sys_clk);
                checkIdleOutputs("midreset");
                sys_reset = 1'b0;
                break;
            end
            if (done) begin
                got = k;
                break;
            end
        end
        start_in = 1'b0;
        if (reset_cyc > 0) begin
            repeat (4) @(negedge sys_clk);
            checkOutput("midreset_no_done", done_cnt, 0);
        end else begin
            checkOutput("done_cycle", got, 2 * n + 2);
            checkOutput("busy_cycles", busy_cnt, 2 * n + 1);
            checkOutput("busy_at_done", busy, 0);
            repeat (3) @(negedge sys_clk);
            checkOutput("done_count", done_cnt, 1);
            checkOutput("err_count", err_cnt, 0);
        end
        checkOutput("wr_drain", exp_wr.size(), 0);
        checkOutput("rd_drain", exp_rd.size(), 0);
        exp_wr.delete();
        exp_rd.delete();
    endtask

    task automatic fillRandom(input logic [7:0] first, input int count);
        for (int i = 0; i < count; i++) mem[8'(first + 8'(i))] = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        sys_reset = 1'b1;
        start_in = 1'b0;
        base_a = '0; base_b = '0; base_dst = '0; nbits = '0; carry_init = 1'b0;
        repeat (3) @(negedge sys_clk);
        checkIdleOutputs("reset");
        sys_reset = 1'b0;
        @(negedge sys_clk);
        checkIdleOutputs("idle");

        $display("[TB] basic 4-bit add, lane0 5+3");
        mem[8'h10] = 32'h1; mem[8'h12] = 32'h1;
        mem[8'h20] = 32'h1; mem[8'h21] = 32'h1;
        applyStimulus(8'h10, 8'h20, 8'h30, 4, 1'b0, 0, 0);
        checkOutput("basic_row30", mem[8'h30], 32'h0);
        checkOutput("basic_row31", mem[8'h31], 32'h0);
        checkOutput("basic_row32", mem[8'h32], 32'h0);
        checkOutput("basic_row33", mem[8'h33], 32'h1);
`ifdef CIM_SEQ_PERF_CNT_EN
        checkOutput("cyc_count", cyc_count, 16'd9);
`endif

        $display("[TB] 8-bit overflow and carry-in");
        for (int i = 0; i < 8; i++) mem[8'h60 + i] = 32'hFFFF_FFFF;
        mem[8'h70] = 32'hFFFF_FFFF;
        applyStimulus(8'h60, 8'h70, 8'h80, 8, 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) checkOutput("ovf_row", mem[8'h80 + i], 32'h0);
        applyStimulus(8'h90, 8'hA0, 8'hB0, 8, 1'b1, 0, 0);
        checkOutput("cin_row0", mem[8'hB0], 32'hFFFF_FFFF);
        for (int i = 1; i < 8; i++) checkOutput("cin_rowN", mem[8'hB0 + i], 32'h0);

        $display("[TB] address wrap");
        fillRandom(8'hFE, 4);
        fillRandom(8'h08, 4);
        applyStimulus(8'hFE, 8'h08, 8'hFE, 4, 1'b0, 0, 0);

        $display("[TB] zero-width command");
        @(negedge sys_clk);
        err_cnt = 0;
        nbits = '0;
        start_in = 1'b1;
        @(negedge sys_clk);
        start_in = 1'b0;
        checkOutput("err_pulse", err, 1);
        checkOutput("err_busy", busy, 0);
        checkOutput("err_load", load_carry, 0);
        repeat (3) @(negedge sys_clk);
        checkOutput("err_once", err_cnt, 1);
        checkIdleOutputs("after_err");

        $display("[TB] start while busy is ignored");
        fillRandom(8'hC0, 4);
        fillRandom(8'hD0, 4);
        applyStimulus(8'hC0, 8'hD0, 8'hE0, 4, 1'b1, 4, 0);

        $display("[TB] in-place add");
        for (int i = 0; i < 3; i++) begin
            mem[8'h40 + i] = '0;
            mem[8'h50 + i] = '0;
        end
        mem[8'h41] = 32'h20;
        mem[8'h50] = 32'h20; mem[8'h51] = 32'h20;
        applyStimulus(8'h40, 8'h50, 8'h40, 3, 1'b0, 0, 0);
        checkOutput("inplace_row40", mem[8'h40], 32'h20);
        checkOutput("inplace_row41", mem[8'h41], 32'h0);
        checkOutput("inplace_row42", mem[8'h42], 32'h20);

        $display("[TB] reset in third WRITE, then recovery");
        fillRandom(8'h00, 8);
        fillRandom(8'h10, 8);
        applyStimulus(8'h00, 8'h10, 8'h20, 8, 1'b0, 0, 7);
        applyStimulus(8'h00, 8'h10, 8'h28, 2, 1'b1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
